// File: rtl/qbus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qbus_pkg
//  Description : Shared QBUS slave definitions. This covers the bus-cycle
//                state encoding and the data, address and I/O page widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package qbus_pkg;

    localparam int QBUS_DATA_W   = 16;
    localparam int QBUS_ADDR_W   = 22;
    localparam int IOPAGE_ADDR_W = 13;

    // Bus-cycle engine states
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        MATCH   = 4'd1,
        NOMATCH = 4'd2,
        CMD     = 4'd3,
        RD      = 4'd4,
        RDH     = 4'd5,
        WR      = 4'd6,
        WRH     = 4'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/qslave_cycle_if.sv
`default_nettype none
// ============================================================================
//  Module      : qslave_cycle_if
//  Description : Internal I/O bus between the QBUS slave cycle engine
//                (master modport) and the I/O page devices (slave modport).
//                iWAIT is present only when QSLAVE_IOWAIT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface qslave_cycle_if #(
    parameter int ADDR_W = qbus_pkg::IOPAGE_ADDR_W
);
    logic [ADDR_W-1:0]                iADDR;
    logic                             iBS7;
    logic                             iREAD_MATCH;
    logic                             iWRITE_MATCH;
    logic [qbus_pkg::QBUS_DATA_W-1:0] iRDATA;
    logic [qbus_pkg::QBUS_DATA_W-1:0] iWDATA;
    logic                             iWRITE;
`ifdef QSLAVE_IOWAIT_EN
    logic                             iWAIT;
`endif

    modport master (
        output iADDR, iBS7, iWDATA, iWRITE,
        input  iREAD_MATCH, iWRITE_MATCH, iRDATA
`ifdef QSLAVE_IOWAIT_EN
        , input iWAIT
`endif
    );

    modport slave (
        input  iADDR, iBS7, iWDATA, iWRITE,
        output iREAD_MATCH, iWRITE_MATCH, iRDATA
`ifdef QSLAVE_IOWAIT_EN
        , output iWAIT
`endif
    );

endinterface
`default_nettype wire

// File: rtl/qslave_cycle_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchroniser bank for asynchronous level signals.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two register stages to resolve metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/qslave_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : qslave_cycle
//  Description : QBUS slave bus-cycle engine. It synchronises the QBUS
//                strobes, latches the address on SYNC and runs DATI/DATO/DATIO
//                cycles on the internal I/O bus. It also drives TRPLY and the
//                Am2908 DAL transceiver controls.
//                Optional: QSLAVE_IOWAIT_EN adds iWAIT device wait states.
//  Revision    : 1.0 - initial release
// ============================================================================
module qslave_cycle
    import qbus_pkg::*;
#(
    parameter int ADDR_W   = IOPAGE_ADDR_W,
    parameter int DAL_HOLD = 2              // must be >= 1
) (
    input  logic                   qclk,
    input  logic                   reset_n,
    input  logic                   RSYNC,
    input  logic                   RDIN,
    input  logic                   RDOUT,
    input  logic                   RINIT,
    input  logic                   ZBS7,
    input  logic                   ZWTBT,
    input  logic [QBUS_ADDR_W-1:0] dal_in,
    output logic [QBUS_DATA_W-1:0] dal_out,
    output logic                   dal_oe,
    output logic                   DALtx,
    output logic                   DALst,
    output logic                   TRPLY,
    qslave_cycle_if.master         io
);

    localparam int c_hold_w = (DAL_HOLD > 1) ? $clog2(DAL_HOLD) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(DAL_HOLD - 1);

    logic [3:0] w_strb;
    logic       w_sync;
    logic       w_din;
    logic       w_dout;
    logic       w_init;

    state_t                  r_state;
    logic                    r_sync_prev;
    logic [QBUS_DATA_W-1:0]  r_dal_out;
    logic                    r_dal_oe;
    logic                    r_daltx;
    logic                    r_dalst;
    logic                    r_trply;
    logic [ADDR_W-1:0]       r_iaddr;
    logic                    r_ibs7;
    logic                    r_wtbt;
    logic [QBUS_DATA_W-1:0]  r_iwdata;
    logic                    r_iwrite;
    logic [c_hold_w-1:0]     r_hold;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (qclk),
        .rst_n (reset_n),
        .d     ({RINIT, RDOUT, RDIN, RSYNC}),
        .q     (w_strb)
    );

    assign w_sync = w_strb[0];
    assign w_din  = w_strb[1];
    assign w_dout = w_strb[2];
    assign w_init = w_strb[3];

    // Bus-cycle FSM; all QBUS and I/O bus outputs are registered here
    always_ff @(posedge qclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_sync_prev <= 1'b0;
            r_dal_out   <= '0;
            r_dal_oe    <= 1'b0;
            r_daltx     <= 1'b0;
            r_dalst     <= 1'b0;
            r_trply     <= 1'b0;
            r_iaddr     <= '0;
            r_ibs7      <= 1'b0;
            r_wtbt      <= 1'b0;
            r_iwdata    <= '0;
            r_iwrite    <= 1'b0;
            r_hold      <= '0;
        end else begin
            r_sync_prev <= w_sync;
            r_dalst     <= 1'b0;
            r_iwrite    <= 1'b0;
            if (w_init) begin
                r_state   <= IDLE;
                r_dal_out <= '0;
                r_dal_oe  <= 1'b0;
                r_daltx   <= 1'b0;
                r_trply   <= 1'b0;
                r_iaddr   <= '0;
                r_ibs7    <= 1'b0;
                r_wtbt    <= 1'b0;
                r_iwdata  <= '0;
                r_hold    <= '0;
            end else if (!w_sync && (r_state inside {RD, RDH, WR, WRH})) begin
                // Master dropped SYNC mid-transfer: release the bus at once
                r_trply  <= 1'b0;
                r_dal_oe <= 1'b0;
                r_daltx  <= 1'b0;
                r_state  <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_sync && !r_sync_prev) begin
                            // Address is held stable by the master across SYNC
                            r_iaddr <= dal_in[ADDR_W-1:0];
                            r_ibs7  <= ZBS7;
                            r_wtbt  <= ZWTBT;
                            r_state <= MATCH;
                        end
                    end
                    MATCH: begin
                        if (r_ibs7 && (io.iREAD_MATCH || io.iWRITE_MATCH))
                            r_state <= CMD;
                        else
                            r_state <= NOMATCH;
                    end
                    NOMATCH: begin
                        if (!w_sync)
                            r_state <= IDLE;
                    end
                    CMD: begin
                        if (!w_sync) begin
                            r_state <= IDLE;
                        end else if (w_din) begin
                            if (io.iREAD_MATCH) begin
                                r_dal_out <= io.iRDATA;
                                r_dal_oe  <= 1'b1;
                                r_daltx   <= 1'b1;
                                r_dalst   <= 1'b1;
                                r_state   <= RD;
                            end else begin
                                r_state <= NOMATCH;
                            end
                        end else if (w_dout) begin
                            if (io.iWRITE_MATCH) begin
                                r_iwdata <= dal_in[QBUS_DATA_W-1:0];
                                r_iwrite <= 1'b1;
                                r_state  <= WR;
                            end else begin
                                r_state <= NOMATCH;
                            end
                        end
                    end
                    RD: begin
`ifdef QSLAVE_IOWAIT_EN
                        if (io.iWAIT) begin
                            r_dal_out <= io.iRDATA;
                        end else begin
                            r_trply <= 1'b1;
                            r_state <= RDH;
                        end
`else
                        r_trply <= 1'b1;
                        r_state <= RDH;
`endif
                    end
                    RDH: begin
                        // DAL stays driven for DAL_HOLD cycles after the reply ends
                        if (r_trply) begin
                            if (!w_din) begin
                                r_trply <= 1'b0;
                                r_hold  <= c_hold_last;
                            end
                        end else if (r_hold == '0) begin
                            r_dal_oe <= 1'b0;
                            r_daltx  <= 1'b0;
                            r_state  <= CMD;
                        end else begin
                            r_hold <= r_hold - 1'b1;
                        end
                    end
                    WR: begin
`ifdef QSLAVE_IOWAIT_EN
                        if (!io.iWAIT) begin
                            r_trply <= 1'b1;
                            r_state <= WRH;
                        end
`else
                        r_trply <= 1'b1;
                        r_state <= WRH;
`endif
                    end
                    WRH: begin
                        if (!w_dout) begin
                            r_trply <= 1'b0;
                            r_state <= CMD;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Byte-write flag and upper DAL bits are received but not acted upon
    logic w_unused;
    assign w_unused = ^{r_wtbt, dal_in[QBUS_ADDR_W-1:QBUS_DATA_W]};

    assign dal_out   = r_dal_out;
    assign dal_oe    = r_dal_oe;
    assign DALtx     = r_daltx;
    assign DALst     = r_dalst;
    assign TRPLY     = r_trply;
    assign io.iADDR  = r_iaddr;
    assign io.iBS7   = r_ibs7;
    assign io.iWDATA = r_iwdata;
    assign io.iWRITE = r_iwrite;

endmodule
`default_nettype wire

// File: tb/tb_qslave_cycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qslave_cycle
//  Description : Self-checking bench for qslave_cycle. It uses a register-file
//                device on the I/O bus and a memory scoreboard of expected
//                contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qslave_cycle;
    import qbus_pkg::*;

    localparam int ADDR_W   = 13;
    localparam int DAL_HOLD = 2;

    logic        qclk = 1'b0;
    logic        reset_n, RSYNC, RDIN, RDOUT, RINIT, ZBS7, ZWTBT;
    logic [21:0] dal_in;
    logic [15:0] dal_out;
    logic        dal_oe, DALtx, DALst, TRPLY;

    int n_assert = 0;
    int n_fail   = 0;

    qslave_cycle_if #(.ADDR_W(ADDR_W)) bus ();

    qslave_cycle #(.ADDR_W(ADDR_W), .DAL_HOLD(DAL_HOLD)) dut (
        .qclk    (qclk),
        .reset_n (reset_n),
        .RSYNC   (RSYNC),
        .RDIN    (RDIN),
        .RDOUT   (RDOUT),
        .RINIT   (RINIT),
        .ZBS7    (ZBS7),
        .ZWTBT   (ZWTBT),
        .dal_in  (dal_in),
        .dal_out (dal_out),
        .dal_oe  (dal_oe),
        .DALtx   (DALtx),
        .DALst   (DALst),
        .TRPLY   (TRPLY),
        .io      (bus)
    );

    always #25 qclk = ~qclk;

    // Device: three registers in the I/O page, slot 3 means "not claimed"
    function automatic logic [1:0] dev_slot(input logic [12:0] a);
        case (a)
            13'o14440: dev_slot = 2'd0;
            13'o14560: dev_slot = 2'd1;
            13'o14570: dev_slot = 2'd2;
            default:   dev_slot = 2'd3;
        endcase
    endfunction

    logic [15:0] dev_mem [4];
    logic [15:0] exp_mem [4];
    logic        dev_init    = 1'b1;
    logic        wait_ovr    = 1'b0;
    logic [15:0] wait_data   = 16'h0;
    logic [15:0] last_wait   = 16'h0;
    int          wr_pulses   = 0;
    logic [15:0] last_wdata  = 16'h0;

    always_comb begin
        bus.iREAD_MATCH  = (dev_slot(bus.iADDR) != 2'd3);
        bus.iWRITE_MATCH = (dev_slot(bus.iADDR) != 2'd3);
        bus.iRDATA       = wait_ovr ? wait_data : dev_mem[dev_slot(bus.iADDR)];
    end

    always @(posedge qclk) begin
        if (dev_init) begin
            dev_mem[0] <= 16'o123456;
            dev_mem[1] <= 16'o123456;
            dev_mem[2] <= 16'o000000;
            dev_mem[3] <= 16'o000000;
        end else if (bus.iWRITE) begin
            dev_mem[dev_slot(bus.iADDR)] <= bus.iWDATA;
        end
        if (bus.iWRITE) begin
            wr_pulses  <= wr_pulses + 1;
            last_wdata <= bus.iWDATA;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, expv);
        end
    endtask

    task automatic sync_on(input logic [21:0] addr, input logic bs7);
        @(negedge qclk);
        dal_in = addr;
        ZBS7   = bs7;
        ZWTBT  = 1'($urandom);
        RSYNC  = 1'b1;
        repeat (4) @(negedge qclk);
        dal_in = 22'($urandom);
    endtask

    task automatic sync_off();
        @(negedge qclk);
        RSYNC = 1'b0;
        ZBS7  = 1'b0;
        repeat (4) @(negedge qclk);
        check("idle_trply_oe", {TRPLY, dal_oe, DALtx}, 0);
    endtask

    // Latencies include the two synchroniser stages on the raw strobe
    task automatic do_read(input logic claimed, input logic [15:0] expv);
        int   lat;
        int   st_at;
        logic seen_oe;
        @(negedge qclk);
        RDIN = 1'b1; lat = 0; st_at = 0; seen_oe = 1'b0;
        while (!TRPLY && lat < 10) begin
            @(negedge qclk);
            lat++;
            if (DALst)  st_at = lat;
            if (dal_oe) seen_oe = 1'b1;
        end
        if (claimed) begin
            check("rd_trply_lat", lat, 4);
            check("rd_dalst_at", st_at, 3);
            check("rd_data", dal_out, expv);
            check("rd_oe_tx", {dal_oe, DALtx}, 2'b11);
            repeat (2) @(negedge qclk);
            check("rd_trply_held", TRPLY, 1);
            RDIN = 1'b0; lat = 0;
            while (TRPLY && lat < 10) begin
                @(negedge qclk);
                lat++;
            end
            check("rd_trply_neg_lat", lat, 3);
            check("rd_oe_hold", dal_oe, 1);
            repeat (DAL_HOLD - 1) @(negedge qclk);
            check("rd_oe_hold_last", dal_oe, 1);
            @(negedge qclk);
            check("rd_oe_release", {dal_oe, DALtx}, 0);
        end else begin
            check("nm_rd_no_trply", lat, 10);
            check("nm_rd_no_oe", seen_oe, 0);
            RDIN = 1'b0;
            repeat (3) @(negedge qclk);
        end
    endtask

    task automatic do_write(input logic claimed, input logic [15:0] data);
        int lat;
        int w0;
        @(negedge qclk);
        dal_in = {6'($urandom), data};
        RDOUT  = 1'b1;
        w0 = wr_pulses; lat = 0;
        while (!TRPLY && lat < 10) begin
            @(negedge qclk);
            lat++;
        end
        if (claimed) begin
            check("wr_trply_lat", lat, 4);
            repeat (2) @(negedge qclk);
            check("wr_trply_held", TRPLY, 1);
            RDOUT = 1'b0; lat = 0;
            while (TRPLY && lat < 10) begin
                @(negedge qclk);
                lat++;
            end
            check("wr_trply_neg_lat", lat, 3);
            check("wr_pulse_count", wr_pulses - w0, 1);
            check("wr_data", last_wdata, data);
        end else begin
            check("nm_wr_no_trply", lat, 10);
            RDOUT = 1'b0;
            repeat (3) @(negedge qclk);
            check("nm_wr_no_pulse", wr_pulses - w0, 0);
        end
    endtask

    // One complete bus cycle, expectations taken from the scoreboard
    task automatic bus_cycle(input logic [21:0] addr, input logic bs7,
                             input logic wr, input logic [15:0] data);
        logic [1:0] s;
        logic       claimed;
        s = dev_slot(addr[12:0]);
        claimed = bs7 && (s != 2'd3);
        sync_on(addr, bs7);
        if (wr) begin
            do_write(claimed, data);
            if (claimed) exp_mem[s] = data;
        end else begin
            do_read(claimed, exp_mem[s]);
        end
        sync_off();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [21:0] a;
        reset_n = 1'b0; RSYNC = 1'b0; RDIN = 1'b0; RDOUT = 1'b0; RINIT = 1'b0;
        ZBS7 = 1'b0; ZWTBT = 1'b0; dal_in = '0;
`ifdef QSLAVE_IOWAIT_EN
        bus.iWAIT = 1'b0;
`endif
        exp_mem[0] = 16'o123456; exp_mem[1] = 16'o123456;
        exp_mem[2] = 16'o000000; exp_mem[3] = 16'o000000;
        repeat (3) @(negedge qclk);
        check("rst_outputs", {TRPLY, dal_oe, DALtx, DALst, bus.iWRITE, bus.iBS7}, 0);
        check("rst_dal_out", dal_out, 0);
        check("rst_iaddr", bus.iADDR, 0);
        check("rst_iwdata", bus.iWDATA, 0);
        reset_n  = 1'b1;
        dev_init = 1'b0;
        repeat (3) @(negedge qclk);

        // Directed cycles
        bus_cycle(22'o17774440, 1'b1, 1'b0, 16'h0);
        bus_cycle(22'o17774440, 1'b1, 1'b1, 16'o054321);
        bus_cycle(22'o17774400, 1'b1, 1'b0, 16'h0);
        bus_cycle(22'o17774440, 1'b0, 1'b0, 16'h0);
        bus_cycle(22'o17774440, 1'b0, 1'b1, 16'o077777);
        bus_cycle(22'o17774440, 1'b1, 1'b0, 16'h0);

        // DATIO: read then write inside one SYNC
        sync_on(22'o17774560, 1'b1);
        do_read(1'b1, exp_mem[1]);
        do_write(1'b1, 16'o054545);
        exp_mem[1] = 16'o054545;
        sync_off();
        bus_cycle(22'o17774560, 1'b1, 1'b0, 16'h0);

        // Asynchronous reset while replying to a read
        sync_on(22'o17774440, 1'b1);
        @(negedge qclk);
        RDIN = 1'b1; lat = 0;
        while (!TRPLY && lat < 10) begin @(negedge qclk); lat++; end
        check("arst_reached_rdh", TRPLY, 1);
        #5 reset_n = 1'b0;
        #1 check("arst_release", {TRPLY, dal_oe, DALtx}, 0);
        @(negedge qclk);
        RDIN = 1'b0; RSYNC = 1'b0; ZBS7 = 1'b0;
        reset_n = 1'b1;
        repeat (4) @(negedge qclk);
        bus_cycle(22'o17774440, 1'b1, 1'b0, 16'h0);

        // RINIT while replying to a read: takes effect after synchronisation
        sync_on(22'o17774440, 1'b1);
        @(negedge qclk);
        RDIN = 1'b1; lat = 0;
        while (!TRPLY && lat < 10) begin @(negedge qclk); lat++; end
        RINIT = 1'b1;
        repeat (2) @(negedge qclk);
        check("rinit_not_yet", TRPLY, 1);
        @(negedge qclk);
        check("rinit_release", {TRPLY, dal_oe, DALtx}, 0);
        RINIT = 1'b0; RDIN = 1'b0; RSYNC = 1'b0; ZBS7 = 1'b0;
        repeat (4) @(negedge qclk);
        bus_cycle(22'o17774560, 1'b1, 1'b0, 16'h0);

        // Randomised cycles against the scoreboard
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 4))
                0:       a = 22'o17774440;
                1:       a = 22'o17774560;
                2:       a = 22'o17774570;
                3:       a = 22'o17774400;
                default: a = 22'o17770440;
            endcase
            bus_cycle(a, ($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom));
        end

`ifdef QSLAVE_IOWAIT_EN
        // Device holds iWAIT for five RD cycles, changing data each cycle
        sync_on(22'o17774440, 1'b1);
        @(negedge qclk);
        RDIN = 1'b1; lat = 0;
        while (!DALst && lat < 10) begin @(negedge qclk); lat++; end
        check("wait_dalst_lat", lat, 3);
        bus.iWAIT = 1'b1;
        wait_ovr  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge qclk);
            check("wait_trply_off", TRPLY, 0);
            wait_data = 16'($urandom);
            last_wait = wait_data;
        end
        @(negedge qclk);
        check("wait_trply_still_off", TRPLY, 0);
        bus.iWAIT = 1'b0;
        wait_data = ~last_wait;
        @(negedge qclk);
        check("wait_trply_on", TRPLY, 1);
        check("wait_rd_data", dal_out, last_wait);
        RDIN = 1'b0; lat = 0;
        while (TRPLY && lat < 10) begin @(negedge qclk); lat++; end
        check("wait_trply_neg_lat", lat, 3);
        wait_ovr = 1'b0;
        repeat (DAL_HOLD + 1) @(negedge qclk);
        sync_off();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
